// File: rtl/button_debouncer.sv
// Input conditioning for buttons and switches: per-bit synchroniser chain followed by
// a tick-qualified stability counter that only lets a level through once it has settled.
module button_debouncer #(
  parameter int WIDTH        = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] changed
);

  localparam int CNT_W = ($clog2(STABLE_TICKS + 1) < 1) ? 1 : $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt    [WIDTH];
  logic [WIDTH-1:0] s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= {WIDTH{RESET_LEVEL}};
    end else begin
      sync_q[0] <= in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
    end
  end

  // Any cycle where the synchronised level matches out discards progress, tick or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= {WIDTH{RESET_LEVEL}};
      changed <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        changed[i] <= 1'b0;
        if (s[i] == out[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            out[i]     <= s[i];
            cnt[i]     <= '0;
            changed[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: one default instance, one 3-bit active-low
// instance and one STABLE_TICKS=1 instance, all sharing clock, reset and tick.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [0:0] in_a, out_a, ch_a;
  logic [2:0] in_b, out_b, ch_b;
  logic [0:0] in_c, out_c, ch_c;

  int total_checks  = 0;
  int passed_checks = 0;

  always #5 clk = ~clk;

  button_debouncer #(.WIDTH(1), .SYNC_STAGES(2), .STABLE_TICKS(4), .RESET_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .in(in_a), .out(out_a), .changed(ch_a));

  button_debouncer #(.WIDTH(3), .SYNC_STAGES(2), .STABLE_TICKS(4), .RESET_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .in(in_b), .out(out_b), .changed(ch_b));

  button_debouncer #(.WIDTH(1), .SYNC_STAGES(2), .STABLE_TICKS(1), .RESET_LEVEL(1'b0)) dut_c (
    .clk(clk), .rst(rst), .tick(tick), .in(in_c), .out(out_c), .changed(ch_c));

  typedef struct {
    logic rst;
    logic tick;
    logic in;
    logic exp_out;
    logic exp_ch;
  } vec_t;

  vec_t vecs[$];

  // Each row's inputs are applied before one rising edge; outputs are checked just after it.
  task automatic applyStimulus(input logic r, input logic t);
    rst  = r;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic addVec(input logic r, input logic t, input logic i, input logic o, input logic c);
    vec_t v;
    v.rst = r; v.tick = t; v.in = i; v.exp_out = o; v.exp_ch = c;
    vecs.push_back(v);
  endtask

  task automatic resetAll();
    in_a = 1'b0; in_b = 3'b111; in_c = 1'b0;
    applyStimulus(1'b1, 1'b1);
  endtask

  // Slow tick: tick on cycles where c%8==7; optional one-cycle low glitch on in.
  task automatic runSlowTick(input string name, input int glitch_cycle, input int rise_edge);
    resetAll();
    for (int c = 0; c <= rise_edge + 3; c++) begin
      in_a = (c == glitch_cycle) ? 1'b0 : 1'b1;
      applyStimulus(1'b0, (c % 8) == 7);
      checkOutput({name, "_out"}, {2'b0, out_a}, {2'b0, 1'(c >= rise_edge)});
      checkOutput({name, "_ch"},  {2'b0, ch_a},  {2'b0, 1'(c == rise_edge)});
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1;
    in_a = 1'b0; in_b = 3'b111; in_c = 1'b0;

    // Clean step: in sampled at row 1 (edge k), out rises at k+5.
    addVec(1, 1, 0, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 1, 1);
    addVec(0, 1, 1, 1, 0);
    addVec(0, 1, 1, 1, 0);
    // Reset mid-count: count reaches 2, then rst; restart from edge r (first rst=0 edge).
    addVec(1, 1, 0, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(1, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 1, 1, 1);
    addVec(0, 1, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      in_a = vecs[i].in;
      applyStimulus(vecs[i].rst, vecs[i].tick);
      checkOutput($sformatf("table%0d_out", i), {2'b0, out_a}, {2'b0, vecs[i].exp_out});
      checkOutput($sformatf("table%0d_ch", i),  {2'b0, ch_a},  {2'b0, vecs[i].exp_ch});
    end

    // Bounce rejection ending low.
    resetAll();
    for (int c = 0; c < 32; c++) begin
      in_a = (c < 24) ? 1'(((c / 2) % 2) == 0) : 1'b0;
      applyStimulus(1'b0, 1'b1);
      checkOutput("bounce_low_out", {2'b0, out_a}, 3'b000);
      checkOutput("bounce_low_ch",  {2'b0, ch_a},  3'b000);
    end

    // Bounce ending with in held high: out rises 5 edges after the final rise is sampled.
    resetAll();
    for (int c = 0; c < 24; c++) begin
      in_a = 1'(((c / 2) % 2) == 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("bounce_pre_out", {2'b0, out_a}, 3'b000);
    end
    for (int j = 0; j < 8; j++) begin
      in_a = 1'b1;
      applyStimulus(1'b0, 1'b1);
      checkOutput("bounce_high_out", {2'b0, out_a}, {2'b0, 1'(j >= 5)});
      checkOutput("bounce_high_ch",  {2'b0, ch_a},  {2'b0, 1'(j == 5)});
    end

    // Slow tick: ticks at edges 7,15,23,31; glitch at 18 clears count, rise moves to 47.
    runSlowTick("slow", -1, 31);
    runSlowTick("slow_glitch", 18, 47);

    // Multi-bit active-low instance.
    resetAll();
    checkOutput("multi_reset_out", out_b, 3'b111);
    checkOutput("multi_reset_ch",  ch_b,  3'b000);
    for (int j = 0; j < 10; j++) begin
      in_b = (j >= 2) ? 3'b010 : 3'b110;
      applyStimulus(1'b0, 1'b1);
      checkOutput("multi_out", out_b, {1'(j < 7), 1'b1, 1'(j < 5)});
      checkOutput("multi_ch",  ch_b,  {1'(j == 7), 1'b0, 1'(j == 5)});
    end

    // STABLE_TICKS=1: each transition appears two edges after it is sampled.
    resetAll();
    for (int j = 0; j < 4; j++) begin
      in_c = 1'b1;
      applyStimulus(1'b0, 1'b1);
      checkOutput("st1_rise_out", {2'b0, out_c}, {2'b0, 1'(j >= 2)});
      checkOutput("st1_rise_ch",  {2'b0, ch_c},  {2'b0, 1'(j == 2)});
    end
    for (int j = 0; j < 4; j++) begin
      in_c = 1'b0;
      applyStimulus(1'b0, 1'b1);
      checkOutput("st1_fall_out", {2'b0, out_c}, {2'b0, 1'(j < 2)});
      checkOutput("st1_fall_ch",  {2'b0, ch_c},  {2'b0, 1'(j == 2)});
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
